// File: rtl/butterfly_r2_pipe.sv
// Radix-2 DIT butterfly with a run-time twiddle: y0 = a + b*W, y1 = a - b*W.
// Four-stage pipeline with global stall, conj(W) select, optional /2 scaling, saturation and sticky overflow.
module butterfly_r2_pipe #(
  parameter int DATA_WIDTH = 16,
  parameter int TW_WIDTH   = 16,
  parameter int LATENCY    = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         in_valid,
  input  logic                         inverse,
  input  logic                         scale,
  input  logic signed [DATA_WIDTH-1:0] a_re,
  input  logic signed [DATA_WIDTH-1:0] a_im,
  input  logic signed [DATA_WIDTH-1:0] b_re,
  input  logic signed [DATA_WIDTH-1:0] b_im,
  input  logic signed [TW_WIDTH-1:0]   w_re,
  input  logic signed [TW_WIDTH-1:0]   w_im,
  output logic                         out_valid,
  output logic signed [DATA_WIDTH-1:0] y0_re,
  output logic signed [DATA_WIDTH-1:0] y0_im,
  output logic signed [DATA_WIDTH-1:0] y1_re,
  output logic signed [DATA_WIDTH-1:0] y1_im,
  output logic                         ovf,
  input  logic                         ovf_clr
);

  localparam int DW = DATA_WIDTH;
  localparam int TW = TW_WIDTH;
  localparam int WW = TW + 1;
  localparam int MW = DW + TW + 1;
  localparam int PW = DW + TW + 2;
  localparam int SW = DW + 2;

  localparam logic signed [PW-1:0] RND     = PW'(1) <<< (TW - 2);
  localparam logic signed [SW-1:0] SAT_MAX = SW'({1'b0, {(DW-1){1'b1}}});
  localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;
  localparam logic signed [SW-1:0] ONE     = SW'(1);

  if (LATENCY != 4) begin : g_latency_check
    $fatal(1, "butterfly_r2_pipe supports only LATENCY=4");
  end

  logic                 v1, sc1;
  logic signed [DW-1:0] a1_re, a1_im, b1_re, b1_im;
  logic signed [WW-1:0] w1_re, w1_im;

  // Twiddle is widened by one bit so conj(-2^(TW-1)) becomes +2^(TW-1) instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1    <= 1'b0;
      sc1   <= 1'b0;
      a1_re <= '0;
      a1_im <= '0;
      b1_re <= '0;
      b1_im <= '0;
      w1_re <= '0;
      w1_im <= '0;
    end else if (en) begin
      v1    <= in_valid;
      sc1   <= scale;
      a1_re <= a_re;
      a1_im <= a_im;
      b1_re <= b_re;
      b1_im <= b_im;
      w1_re <= WW'(w_re);
      w1_im <= inverse ? -WW'(w_im) : WW'(w_im);
    end
  end

  logic signed [MW-1:0] p_rr, p_ii, p_ri, p_ir;

  assign p_rr = MW'(b1_re) * MW'(w1_re);
  assign p_ii = MW'(b1_im) * MW'(w1_im);
  assign p_ri = MW'(b1_re) * MW'(w1_im);
  assign p_ir = MW'(b1_im) * MW'(w1_re);

  logic                 v2, sc2;
  logic signed [DW-1:0] a2_re, a2_im;
  logic signed [PW-1:0] pr2, pi2;

  always_ff @(posedge clk) begin
    if (rst) begin
      v2    <= 1'b0;
      sc2   <= 1'b0;
      a2_re <= '0;
      a2_im <= '0;
      pr2   <= '0;
      pi2   <= '0;
    end else if (en) begin
      v2    <= v1;
      sc2   <= sc1;
      a2_re <= a1_re;
      a2_im <= a1_im;
      pr2   <= PW'(p_rr) - PW'(p_ii);
      pi2   <= PW'(p_ri) + PW'(p_ir);
    end
  end

  logic                 v3, sc3;
  logic signed [DW-1:0] a3_re, a3_im;
  logic signed [SW-1:0] tr3, ti3;

  // Round half-up back to data scale; the upper bits dropped by the cast are pure sign extension.
  always_ff @(posedge clk) begin
    if (rst) begin
      v3    <= 1'b0;
      sc3   <= 1'b0;
      a3_re <= '0;
      a3_im <= '0;
      tr3   <= '0;
      ti3   <= '0;
    end else if (en) begin
      v3    <= v2;
      sc3   <= sc2;
      a3_re <= a2_re;
      a3_im <= a2_im;
      tr3   <= SW'((pr2 + RND) >>> (TW - 1));
      ti3   <= SW'((pi2 + RND) >>> (TW - 1));
    end
  end

  logic signed [SW-1:0] raw [4];
  logic signed [SW-1:0] scaled [4];
  logic signed [DW-1:0] clamped [4];
  logic [3:0]           sat;

  // Component order: y0_re, y0_im, y1_re, y1_im.
  always_comb begin
    raw[0] = SW'(a3_re) + tr3;
    raw[1] = SW'(a3_im) + ti3;
    raw[2] = SW'(a3_re) - tr3;
    raw[3] = SW'(a3_im) - ti3;
    for (int k = 0; k < 4; k++) begin
      scaled[k] = sc3 ? ((raw[k] + ONE) >>> 1) : raw[k];
      sat[k]    = (scaled[k] > SAT_MAX) || (scaled[k] < SAT_MIN);
      if (scaled[k] > SAT_MAX) begin
        clamped[k] = DW'(SAT_MAX);
      end else if (scaled[k] < SAT_MIN) begin
        clamped[k] = DW'(SAT_MIN);
      end else begin
        clamped[k] = DW'(scaled[k]);
      end
    end
  end

  // Overflow set beats clear; clear works even while the pipeline is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      y0_re     <= '0;
      y0_im     <= '0;
      y1_re     <= '0;
      y1_im     <= '0;
      ovf       <= 1'b0;
    end else begin
      if (en) begin
        out_valid <= v3;
        y0_re     <= clamped[0];
        y0_im     <= clamped[1];
        y1_re     <= clamped[2];
        y1_im     <= clamped[3];
      end
      if (en && v3 && (|sat)) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_butterfly_r2_pipe.sv
// Self-checking bench for butterfly_r2_pipe: directed cases with hand-derived values
// plus a random stream with a stall, compared against an arithmetic reference model.
module tb_butterfly_r2_pipe;
  localparam int DW = 16;
  localparam int TW = 16;

  logic clk = 1'b0;
  logic rst, en, in_valid, inverse, scale, ovf_clr;
  logic signed [DW-1:0] a_re, a_im, b_re, b_im;
  logic signed [TW-1:0] w_re, w_im;
  logic out_valid, ovf;
  logic signed [DW-1:0] y0_re, y0_im, y1_re, y1_im;

  int total = 0;
  int bad = 0;

  typedef struct {
    longint y0r, y0i, y1r, y1i;
    bit     sat;
    int     age;
  } exp_t;

  exp_t pending[$];

  always #5 clk = ~clk;

  butterfly_r2_pipe #(.DATA_WIDTH(DW), .TW_WIDTH(TW), .LATENCY(4)) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .inverse(inverse), .scale(scale),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .w_re(w_re), .w_im(w_im),
    .out_valid(out_valid), .y0_re(y0_re), .y0_im(y0_im), .y1_re(y1_re), .y1_im(y1_im),
    .ovf(ovf), .ovf_clr(ovf_clr)
  );

  // Complex multiply, round half-up, add/sub, optional halve and clamp, in plain integer arithmetic.
  function automatic exp_t ref_bfly(input longint ar, ai, br, bi, wr, wi, input bit inv, sc);
    exp_t   e;
    longint wie, pr, pi, tr, ti, half, lim;
    longint s[4];
    wie  = inv ? -wi : wi;
    pr   = br * wr - bi * wie;
    pi   = br * wie + bi * wr;
    half = longint'(1) << (TW - 2);
    tr   = (pr + half) >>> (TW - 1);
    ti   = (pi + half) >>> (TW - 1);
    s[0] = ar + tr;
    s[1] = ai + ti;
    s[2] = ar - tr;
    s[3] = ai - ti;
    lim  = longint'(1) << (DW - 1);
    e.sat = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (sc) s[k] = (s[k] + 1) >>> 1;
      if (s[k] > lim - 1) begin
        s[k] = lim - 1;
        e.sat = 1'b1;
      end else if (s[k] < -lim) begin
        s[k] = -lim;
        e.sat = 1'b1;
      end
    end
    e.y0r = s[0];
    e.y0i = s[1];
    e.y1r = s[2];
    e.y1i = s[3];
    e.age = 0;
    return e;
  endfunction

  function automatic longint rnd16();
    logic signed [15:0] r;
    r = 16'($urandom);
    return longint'(r);
  endfunction

  task automatic apply_stimulus(input bit v, inv, sc, input longint ar, ai, br, bi, wr, wi);
    in_valid = v;
    inverse  = inv;
    scale    = sc;
    a_re = DW'(ar);
    a_im = DW'(ai);
    b_re = DW'(br);
    b_im = DW'(bi);
    w_re = TW'(wr);
    w_im = TW'(wi);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_sample(input string tag, input longint r0, i0, r1, i1);
    check_output({tag, "_vld"}, out_valid, 1);
    check_output({tag, "_y0re"}, y0_re, r0);
    check_output({tag, "_y0im"}, y0_im, i0);
    check_output({tag, "_y1re"}, y1_re, r1);
    check_output({tag, "_y1im"}, y1_im, i1);
  endtask

  task automatic bubble();
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int     sent, received, cyc;
    bit     en_now, expect_valid, model_ovf;
    exp_t   e;
    longint ar, ai, br, bi, wr, wi;
    bit     inv, sc;
    logic signed [DW-1:0] prev_y0r, prev_y1i;
    logic prev_vld, prev_ovf;

    rst = 1'b1;
    en = 1'b1;
    ovf_clr = 1'b0;
    bubble();
    tick();
    tick();
    rst = 1'b0;
    check_output("rst_vld", out_valid, 0);
    check_output("rst_y0re", y0_re, 0);
    check_output("rst_y1im", y1_im, 0);
    check_output("rst_ovf", ovf, 0);

    // Unity twiddle
    apply_stimulus(1, 0, 0, 1000, 0, 1000, 0, 32767, 0);
    tick();
    bubble();
    tick();
    tick();
    check_output("unity_early_vld", out_valid, 0);
    tick();
    check_sample("unity", 2000, 0, 0, 0);
    check_output("unity_ovf", ovf, 0);
    tick();
    check_output("unity_pulse_end", out_valid, 0);

    // -j twiddle forward, then inverse with w_im = -32768 conjugated to +32768
    apply_stimulus(1, 0, 0, 0, 0, 1000, 0, 0, -32768);
    tick();
    apply_stimulus(1, 1, 0, 0, 0, 1000, 0, 0, -32768);
    tick();
    bubble();
    tick();
    tick();
    check_sample("mj_fwd", 0, -1000, 0, 1000);
    tick();
    check_sample("mj_inv", 0, 1000, 0, -1000);

    // Saturation, clear while stalled, then the scaled repeat
    apply_stimulus(1, 0, 0, 30000, 0, 30000, 0, 32767, 0);
    tick();
    bubble();
    tick();
    tick();
    tick();
    check_sample("sat", 32767, 0, 1, 0);
    check_output("sat_ovf", ovf, 1);
    tick();
    check_output("sat_ovf_sticky", ovf, 1);
    en = 1'b0;
    ovf_clr = 1'b1;
    tick();
    check_output("clr_stalled_ovf", ovf, 0);
    en = 1'b1;
    ovf_clr = 1'b0;
    apply_stimulus(1, 0, 1, 30000, 0, 30000, 0, 32767, 0);
    tick();
    bubble();
    tick();
    tick();
    tick();
    check_sample("scaled", 30000, 0, 1, 0);
    check_output("scaled_ovf", ovf, 0);

    // Random stream of 8 samples with a 3-cycle stall; junk offered during the stall must be ignored
    pending.delete();
    sent = 0;
    received = 0;
    model_ovf = 1'b0;
    cyc = 0;
    while ((sent < 8 || pending.size() > 0) && cyc < 60) begin
      en_now = !(cyc >= 4 && cyc < 7);
      en = en_now;
      ar = rnd16(); ai = rnd16(); br = rnd16(); bi = rnd16(); wr = rnd16(); wi = rnd16();
      inv = 1'($urandom);
      sc = 1'($urandom);
      apply_stimulus((sent < 8) || !en_now, inv, sc, ar, ai, br, bi, wr, wi);
      prev_y0r = y0_re;
      prev_y1i = y1_im;
      prev_vld = out_valid;
      prev_ovf = ovf;
      tick();
      if (en_now) begin
        foreach (pending[i]) pending[i].age++;
        if (sent < 8) begin
          e = ref_bfly(ar, ai, br, bi, wr, wi, inv, sc);
          pending.push_back(e);
          sent++;
        end
        expect_valid = (pending.size() > 0) && (pending[0].age == 3);
        check_output("stream_vld", out_valid, expect_valid);
        if (expect_valid) begin
          e = pending.pop_front();
          received++;
          check_sample("stream", e.y0r, e.y0i, e.y1r, e.y1i);
          model_ovf = model_ovf | e.sat;
        end
        check_output("stream_ovf", ovf, model_ovf);
      end else begin
        check_output("stall_vld_hold", out_valid, prev_vld);
        check_output("stall_y0re_hold", y0_re, prev_y0r);
        check_output("stall_y1im_hold", y1_im, prev_y1i);
        check_output("stall_ovf_hold", ovf, prev_ovf);
      end
      cyc++;
    end
    en = 1'b1;
    check_output("stream_count", received, 8);
    check_output("stream_leftover", pending.size(), 0);

    // Set/clear collision: set wins, then a lone clear works
    ovf_clr = 1'b1;
    bubble();
    tick();
    ovf_clr = 1'b0;
    check_output("pre_coll_ovf", ovf, 0);
    apply_stimulus(1, 0, 0, 30000, 0, 30000, 0, 32767, 0);
    tick();
    bubble();
    tick();
    tick();
    ovf_clr = 1'b1;
    tick();
    check_output("coll_y0re", y0_re, 32767);
    check_output("coll_ovf", ovf, 1);
    tick();
    check_output("coll_clr_ovf", ovf, 0);
    ovf_clr = 1'b0;

    // Reset mid-stream with saturating samples in flight and ovf already set
    apply_stimulus(1, 0, 0, -30000, 0, 30000, 0, 32767, 0);
    tick();
    bubble();
    tick();
    tick();
    tick();
    check_output("pre_rst_ovf", ovf, 1);
    apply_stimulus(1, 0, 0, 30000, 0, 30000, 0, 32767, 0);
    tick();
    apply_stimulus(1, 0, 0, 1000, 0, 1000, 0, 32767, 0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_output("mid_rst_vld", out_valid, 0);
    check_output("mid_rst_y0re", y0_re, 0);
    check_output("mid_rst_y0im", y0_im, 0);
    check_output("mid_rst_y1re", y1_re, 0);
    check_output("mid_rst_y1im", y1_im, 0);
    check_output("mid_rst_ovf", ovf, 0);
    bubble();
    for (int i = 0; i < 4; i++) begin
      tick();
      check_output("post_rst_quiet", out_valid, 0);
      check_output("post_rst_ovf", ovf, 0);
    end
    apply_stimulus(1, 0, 0, 1000, 0, 1000, 0, 32767, 0);
    tick();
    bubble();
    tick();
    tick();
    check_output("post_rst_early", out_valid, 0);
    tick();
    check_sample("post_rst", 2000, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/butterfly_r2_pipe.md
Name: butterfly_r2_pipe

Overview:
Parametrised radix-2 DIT butterfly for the FFT datapath: y0 = a + b·W, y1 = a − b·W.
- Twiddle W is a run-time input, not a fixed constant, so one instance serves every stage and twiddle index.
- Adds a valid pipeline, global stall, per-sample forward/inverse selection, optional divide-by-2 stage scaling, output saturation and a sticky overflow flag.
- Sits between the stage address generator/twiddle ROM and the stage memory.

Parameters:
DATA_WIDTH, 16, signed width of a, b, y components
TW_WIDTH, 16, signed width of W components, format Q1.(TW_WIDTH-1)
LATENCY, 4, fixed pipeline depth in cycles; only 4 is supported and any other value is a fatal elaboration error

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  synchronous active-high reset
en  in  1  pipeline advance; 0 = whole pipeline holds
in_valid  in  1  input sample valid
inverse  in  1  1 = use conj(W); sampled with data
scale  in  1  1 = divide outputs by 2 with rounding; sampled with data
a_re, a_im  in  DATA_WIDTH  operand a
b_re, b_im  in  DATA_WIDTH  operand b
w_re, w_im  in  TW_WIDTH  twiddle
out_valid  out  1  outputs valid
y0_re, y0_im, y1_re, y1_im  out  DATA_WIDTH  results
ovf  out  1  sticky saturation flag
ovf_clr  in  1  clears ovf

Behaviour:
- Reset: every pipeline register, including data, control and valid, clears to 0. Outputs are 0, out_valid=0, ovf=0. Reset overrides en. Samples in flight during reset are discarded without a flag.
- Stage 1: register a, b and W, plus in_valid, inverse and scale. If inverse=1, W becomes conj(W): negate w_im at TW_WIDTH+1 bits, so w_im=−2^(TW−1) maps to +2^(TW−1) without wrap.
- Stage 2: four full-precision products, each DATA_WIDTH+TW_WIDTH+1 bits.
  - pr = b_re·w_re − b_im·w_im
  - pi = b_re·w_im + b_im·w_re
  - The sum and difference are kept at DATA_WIDTH+TW_WIDTH+2 bits.
- Stage 3: round half-up: t = (p + 2^(TW−2)) >>> (TW−1), arithmetic shift. Keep t at DATA_WIDTH+2 bits with no truncation.
- Stage 4: s0 = a + t and s1 = a − t, with a sign-extended to DATA_WIDTH+2.
  - If scale=1: s = (s + 1) >>> 1.
  - Saturate each of the 4 components to [−2^(DW−1), 2^(DW−1)−1].
  - Register into y*, and register out_valid.
- Latency: a sample accepted at edge k (in_valid=1, en=1) appears with out_valid=1 after edge k+3. Count only edges where en=1.
- en=0: all stage registers, including valid bits, hold their values, and the outputs hold too. in_valid is ignored while en=0.
- Bubbles: in_valid=0 propagates as out_valid=0. Data registers still load, and y* are don't-care when out_valid=0.
- ovf is set on any edge with en=1 where a stage-4 component with its valid bit set saturates.
  - ovf_clr=1 clears ovf.
  - If set and clear happen on the same edge, set wins.
  - ovf_clr is honoured regardless of en.
- Back-to-back samples on every en=1 cycle give full throughput of 1 sample per cycle.

Test Plan:
- Unity twiddle (DW=TW=16). a=(1000,0), b=(1000,0), w=(32767,0), scale=0, inverse=0 → out_valid pulse 4 cycles later. y0=(2000,0), y1=(0,0), ovf=0.
- −j twiddle, forward then inverse. a=(0,0), b=(1000,0), w=(0,−32768).
  - inverse=0 → y0=(0,−1000), y1=(0,1000).
  - Next cycle, same data with inverse=1 → y0=(0,1000), y1=(0,−1000). The +32768 case must not wrap.
- Saturation and scaling. a=(30000,0), b=(30000,0), w=(32767,0).
  - scale=0 → y0=(32767,0) saturated, y1=(1,0), ovf=1 from that cycle onward.
  - Then ovf_clr=1 for one cycle → ovf=0.
  - Repeat with scale=1 → y0=(30000,0), y1=(1,0), ovf stays 0.
- Stall. Stream 8 consecutive samples with en dropped to 0 for 3 cycles mid-stream → all 8 results emerge in order, none lost or duplicated. Outputs are frozen during the stall, and the affected samples' latency is 4+3 cycles.
- Set/clear collision. Drive ovf_clr=1 on the same edge a saturating sample reaches stage 4 → ovf=1 afterwards.
- Reset mid-stream. Stream samples, assert rst for 1 cycle with en=1 → the next edge shows all y*=0, out_valid=0, ovf=0. No out_valid pulse appears for pre-reset samples; samples entered after reset emerge with 4-cycle latency.
